// File: rtl/l1c_axi_master.sv
// l1c_axi_master
//   Memory-side stage behind an L1 cache controller. A line read from the cache
//   becomes one LINE_WORDS-beat INCR AXI4 read burst. The returned beats are
//   forwarded to the cache one word per cycle. A write-through store becomes
//   one single-beat AXI4 write.
//
//   Ports:
//     clk, rst                 clock and asynchronous active-low reset
//     c_req/c_addr/c_write     cache request; held until c_wait falls
//     c_in/c_type              store data and active-low byte mask
//     c_out/c_valid/c_wait     read beat data, beat strobe, transaction busy
//     AR*/R*/AW*/W*/B*         AXI4 master channels
//     resp_err                 sticky bus error flag
//
//   Build option: define L1C_AXI_RESP_CHECK_EN to make resp_err latch
//   non-OKAY RRESP/BRESP. Without it, resp_err is tied to 0.
module l1c_axi_master #(
  parameter logic [3:0]  ID         = 4'h0,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              c_write,
  input  logic [DATA_W-1:0] c_in,
  input  logic [3:0]        c_type,
  output logic [DATA_W-1:0] c_out,
  output logic              c_valid,
  output logic              c_wait,
  output logic [3:0]        ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [3:0]        RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [3:0]        AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [3:0]        WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [3:0]        BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic              resp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP
  } state_t;

  localparam int unsigned     CNT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_type;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_aw_done;
  logic              r_w_done;
  logic              r_drain;

  logic w_beat;
  logic w_rd_done;
  logic w_aw_hs;
  logic w_w_hs;

  // Request fields are static for the life of a transaction.
  assign ARID    = ID;
  assign ARADDR  = {r_addr[ADDR_W-1:4], 4'h0};
  assign ARLEN   = 8'(LINE_WORDS - 1);
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign AWID    = ID;
  assign AWADDR  = r_addr;
  assign AWLEN   = 8'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign WDATA   = r_wdata;
  assign WSTRB   = ~r_type;
  assign WLAST   = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    c_out     = '0;
    c_valid   = 1'b0;
    c_wait    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    w_beat    = 1'b0;
    w_rd_done = 1'b0;
    w_aw_hs   = 1'b0;
    w_w_hs    = 1'b0;
    case (r_state)
      S_IDLE: begin
        c_wait = c_req;
        // Beats left over from a burst that was cut short by the counter are
        // still accepted here and discarded. A new request waits until RLAST.
        RREADY = r_drain;
        if (c_req && !r_drain) w_next = c_write ? S_WR_REQ : S_RD_ADDR;
      end
      S_RD_ADDR: begin
        c_wait  = 1'b1;
        ARVALID = 1'b1;
        if (ARREADY) w_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        c_wait = 1'b1;
        RREADY = 1'b1;
        if (RVALID) begin
          c_valid = 1'b1;
          c_out   = RDATA;
          w_beat  = 1'b1;
          if (RLAST || (r_cnt == LAST_CNT)) begin
            w_rd_done = 1'b1;
            c_wait    = 1'b0;
            w_next    = S_IDLE;
          end
        end
      end
      S_WR_REQ: begin
        c_wait  = 1'b1;
        AWVALID = !r_aw_done;
        WVALID  = !r_w_done;
        w_aw_hs = !r_aw_done && AWREADY;
        w_w_hs  = !r_w_done && WREADY;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        BREADY = 1'b1;
        c_wait = !BVALID;
        if (BVALID) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_type    <= '1;
      r_cnt     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_drain   <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        if (c_req) begin
          r_addr  <= c_addr;
          r_wdata <= c_in;
          r_type  <= c_type;
        end
        if (r_drain && RVALID && RLAST) r_drain <= 1'b0;
      end
      if (r_state == S_RD_ADDR && ARREADY) r_cnt <= '0;
      if (w_beat)                          r_cnt <= r_cnt + CNT_W'(1);
      if (w_rd_done && !RLAST)             r_drain <= 1'b1;
      if (w_aw_hs)                         r_aw_done <= 1'b1;
      if (w_w_hs)                          r_w_done <= 1'b1;
    end
  end

`ifdef L1C_AXI_RESP_CHECK_EN
  logic r_resp_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_resp_err <= 1'b0;
    else if ((RVALID && RREADY && (RRESP != 2'b00)) ||
             (BVALID && BREADY && (BRESP != 2'b00)))
      r_resp_err <= 1'b1;
  end
  assign resp_err = r_resp_err;

  logic w_unused;
  assign w_unused = &{1'b0, RID, BID};
`else
  assign resp_err = 1'b0;

  logic w_unused;
  assign w_unused = &{1'b0, RID, BID, RRESP, BRESP};
`endif

endmodule

// File: tb/tb_l1c_axi_master.sv
module tb_l1c_axi_master;

  logic        clk;
  logic        rst;
  logic        c_req;
  logic [31:0] c_addr;
  logic        c_write;
  logic [31:0] c_in;
  logic [3:0]  c_type;
  logic [31:0] c_out;
  logic        c_valid;
  logic        c_wait;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        resp_err;

`ifdef L1C_AXI_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  l1c_axi_master #(.ID(4'h0), .LINE_WORDS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_addr(c_addr), .c_write(c_write), .c_in(c_in), .c_type(c_type),
    .c_out(c_out), .c_valid(c_valid), .c_wait(c_wait),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] beats [4];

  initial begin
    rst = 1'b0; c_req = 1'b0; c_addr = '0; c_write = 1'b0; c_in = '0; c_type = 4'hf;
    ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BID = '0; BRESP = '0; BVALID = 1'b0;
    beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33; beats[3] = 32'h44;

    // Reset state
    #12;
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid",  WVALID, 0);
    chk("rst_rready",  RREADY, 0);
    chk("rst_bready",  BREADY, 0);
    chk("rst_cvalid",  c_valid, 0);
    chk("rst_cwait",   c_wait, 0);
    chk("rst_cout",    c_out, 0);
    chk("rst_resp_err", resp_err, 0);
    step();
    rst = 1'b1;
    step();

    // Line read, ARREADY already high, back-to-back beats
    c_req = 1'b1; c_write = 1'b0; c_addr = 32'h0000_1234; ARREADY = 1'b1;
    #1;
    chk("rd_idle_cwait", c_wait, 1);
    chk("rd_idle_arvalid", ARVALID, 0);
    step();
    chk("rd_arvalid", ARVALID, 1);
    chk("rd_araddr",  ARADDR, 32'h0000_1230);
    chk("rd_arlen",   ARLEN, 3);
    chk("rd_arsize",  ARSIZE, 3'b010);
    chk("rd_arburst", ARBURST, 2'b01);
    chk("rd_arid",    ARID, 0);
    step();
    ARREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RVALID = 1'b1; RDATA = beats[i]; RLAST = (i == 3);
      #1;
      chk("rd_rready", RREADY, 1);
      chk("rd_cvalid", c_valid, 1);
      chk("rd_cout",   c_out, beats[i]);
      chk("rd_cwait",  c_wait, (i == 3) ? 0 : 1);
      step();
    end
    c_req = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("rd_done_cwait",  c_wait, 0);
    chk("rd_done_rready", RREADY, 0);
    chk("rd_done_arvalid", ARVALID, 0);
    step();

    // Stalled read: ARREADY low 3 cycles, gaps between beats
    c_req = 1'b1; c_addr = 32'h0000_ABCC;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_arvalid", ARVALID, 1);
      chk("st_araddr",  ARADDR, 32'h0000_ABC0);
      step();
    end
    ARREADY = 1'b1;
    #1;
    chk("st_arvalid_hs", ARVALID, 1);
    chk("st_araddr_hs",  ARADDR, 32'h0000_ABC0);
    step();
    ARREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RVALID = 1'b0;
      #1;
      chk("st_gap_cvalid", c_valid, 0);
      chk("st_gap_cwait",  c_wait, 1);
      chk("st_gap_rready", RREADY, 1);
      step();
      RVALID = 1'b1; RDATA = 32'hA0 + 32'(i); RLAST = (i == 3);
      #1;
      chk("st_cvalid", c_valid, 1);
      chk("st_cout",   c_out, 32'hA0 + 32'(i));
      chk("st_cwait",  c_wait, (i == 3) ? 0 : 1);
      step();
    end
    c_req = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    step();

    // Early RLAST on the 2nd beat ends the transaction
    c_req = 1'b1; c_addr = 32'h0000_6000; ARREADY = 1'b1;
    step();
    step();
    ARREADY = 1'b0;
    RVALID = 1'b1; RDATA = 32'h51; RLAST = 1'b0;
    #1;
    chk("early_b1_cwait", c_wait, 1);
    step();
    RDATA = 32'h52; RLAST = 1'b1;
    #1;
    chk("early_b2_cvalid", c_valid, 1);
    chk("early_b2_cwait",  c_wait, 0);
    step();
    c_req = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("early_no_drain_rready", RREADY, 0);
    step();

    // Late RLAST: counter ends it on the 4th beat, the 5th is drained unforwarded
    c_req = 1'b1; c_addr = 32'h0000_7000; ARREADY = 1'b1;
    step();
    step();
    ARREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RVALID = 1'b1; RDATA = 32'h60 + 32'(i); RLAST = 1'b0;
      #1;
      chk("late_cwait", c_wait, (i == 3) ? 0 : 1);
      step();
    end
    c_req = 1'b0; RVALID = 1'b1; RDATA = 32'h99; RLAST = 1'b1;
    #1;
    chk("drain_rready", RREADY, 1);
    chk("drain_cvalid", c_valid, 0);
    chk("drain_cout",   c_out, 0);
    step();
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("drain_done_rready", RREADY, 0);
    step();

    // Byte write
    c_req = 1'b1; c_write = 1'b1; c_addr = 32'h0000_2006; c_in = 32'hAABB_CCDD; c_type = 4'b1011;
    step();
    AWREADY = 1'b1; WREADY = 1'b1;
    #1;
    chk("wr_awvalid", AWVALID, 1);
    chk("wr_wvalid",  WVALID, 1);
    chk("wr_awaddr",  AWADDR, 32'h0000_2006);
    chk("wr_awlen",   AWLEN, 0);
    chk("wr_wstrb",   WSTRB, 4'b0100);
    chk("wr_wlast",   WLAST, 1);
    chk("wr_wdata",   WDATA, 32'hAABB_CCDD);
    chk("wr_cwait",   c_wait, 1);
    step();
    AWREADY = 1'b0; WREADY = 1'b0;
    #1;
    chk("wr_resp_bready",  BREADY, 1);
    chk("wr_resp_awvalid", AWVALID, 0);
    chk("wr_resp_wvalid",  WVALID, 0);
    chk("wr_resp_cwait",   c_wait, 1);
    step();
    BVALID = 1'b1; BRESP = 2'b00;
    #1;
    chk("wr_b_cwait", c_wait, 0);
    step();
    BVALID = 1'b0; c_req = 1'b0;
    #1;
    chk("wr_done_bready", BREADY, 0);
    chk("wr_ok_resp_err", resp_err, 0);
    step();

    // Split write handshake: W accepted 2 cycles before AW, error response
    c_req = 1'b1; c_write = 1'b1; c_addr = 32'h0000_3000; c_in = 32'h1234_5678; c_type = 4'h0;
    step();
    WREADY = 1'b1;
    #1;
    chk("sp_awvalid0", AWVALID, 1);
    chk("sp_wvalid0",  WVALID, 1);
    step();
    WREADY = 1'b0;
    #1;
    chk("sp_wvalid1",  WVALID, 0);
    chk("sp_awvalid1", AWVALID, 1);
    step();
    AWREADY = 1'b1;
    #1;
    chk("sp_wvalid2",  WVALID, 0);
    chk("sp_awvalid2", AWVALID, 1);
    step();
    AWREADY = 1'b0;
    BVALID = 1'b1; BRESP = 2'b10;
    #1;
    chk("sp_bready",  BREADY, 1);
    chk("sp_awvalid3", AWVALID, 0);
    chk("sp_cwait",   c_wait, 0);
    step();

    // Back-to-back: new read in the cycle after completion
    BVALID = 1'b0; BRESP = 2'b00;
    c_write = 1'b0; c_addr = 32'h0000_4000; ARREADY = 1'b1;
    #1;
    chk("err_set", resp_err, EXP_ERR);
    chk("b2b_cwait", c_wait, 1);
    chk("b2b_bready", BREADY, 0);
    step();
    chk("b2b_arvalid", ARVALID, 1);
    chk("b2b_araddr",  ARADDR, 32'h0000_4000);
    step();
    ARREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      RVALID = 1'b1; RDATA = 32'h70 + 32'(i); RRESP = 2'b00; RLAST = 1'b0;
      step();
    end
    #1;
    chk("err_held", resp_err, EXP_ERR);
    chk("mid_cwait", c_wait, 1);

    // Asynchronous reset in the middle of the burst
    rst = 1'b0; c_req = 1'b0;
    #1;
    chk("mr_arvalid", ARVALID, 0);
    chk("mr_rready",  RREADY, 0);
    chk("mr_cwait",   c_wait, 0);
    chk("mr_cvalid",  c_valid, 0);
    chk("mr_resp_err", resp_err, 0);
    RVALID = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Fresh read after reset release
    c_req = 1'b1; c_addr = 32'h0000_5008;
    #1;
    chk("fr_cwait", c_wait, 1);
    step();
    chk("fr_arvalid", ARVALID, 1);
    chk("fr_araddr",  ARADDR, 32'h0000_5000);
    ARREADY = 1'b1;
    step();
    ARREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RVALID = 1'b1; RDATA = 32'h80 + 32'(i); RLAST = (i == 3);
      #1;
      chk("fr_cout",  c_out, 32'h80 + 32'(i));
      chk("fr_cwait", c_wait, (i == 3) ? 0 : 1);
      step();
    end
    c_req = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("fr_done_cwait", c_wait, 0);
    chk("fr_resp_err", resp_err, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
